// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle RISC-V controller and its datapath.
// Holds the FSM state codes, the opcode constants, the mux select / ALU
// operation encodings, and the immediate-format decode helper. No ports.
package multicycle_ctrl_pkg;

    // State codes are fixed and visible on state_dbg.
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_HALT     = 4'd11
    } state_t;

    // Opcodes
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    // ALU source A select
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_REG   = 2'b10;

    // ALU source B select
    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Result select
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    // Immediate formats
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // ALU operation class
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU operations
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Immediate format from the opcode; unknown opcodes fall back to I-type.
    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        logic [1:0] imm;
        case (op)
            OP_LOAD, OP_ITYPE: imm = IMM_I;
            OP_STORE:          imm = IMM_S;
            OP_BEQ:            imm = IMM_B;
            OP_JAL:            imm = IMM_J;
            default:           imm = IMM_I;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// ALU operation decoder.
// Ports:
//   alu_op      in  2  operation class from the FSM (add / sub / by funct)
//   funct3      in  3  instruction funct3
//   funct7_5    in  1  instruction bit 30
//   op5         in  1  opcode bit 5 (distinguishes R-type from I-type)
//   alu_control out 3  ALU operation
module alu_decoder
    import multicycle_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       op5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b111:  alu_control = ALU_AND;
                    3'b110:  alu_control = ALU_OR;
                    3'b010:  alu_control = ALU_SLT;
                    // Only R-type can subtract; addi with bit 30 set is still add.
                    3'b000:  alu_control = (op5 && funct7_5) ? ALU_SUB : ALU_ADD;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V controller: Moore FSM sequencing fetch/decode/execute,
// memory wait counter with timeout fault, ImmSrc decode and ALU decode.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   op, funct3, funct7_5       instruction fields from IR
//   zero                       ALU zero flag (branch condition)
//   mem_ready                  memory completion
//   PCWrite..AdrSrc            1-bit datapath strobes / selects
//   ResultSrc..ALUOP           2-bit mux selects and ALU op class
//   ALUControl                 ALU operation
//   mem_err                    sticky memory timeout fault
//   illegal_instr              one-cycle pulse on unknown opcode in DECODE
//   state_dbg                  current state code
//
// Memory handshake: in FETCH, MEMREAD and MEMWRITE the request (MemRead or
// MemWrite) is held every cycle; a transfer completes in the cycle where
// mem_ready=1 is sampled with the request asserted, and the FSM leaves the
// state on that edge. mem_ready is ignored in all other states.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT_MAX = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       MemRead,
    output logic       AdrSrc,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [1:0] ALUOP,
    output logic [2:0] ALUControl,
    output logic       mem_err,
    output logic       illegal_instr,
    output logic [3:0] state_dbg
);

    localparam logic [15:0] WAIT_MAX = 16'(MEM_WAIT_MAX);

    state_t      state_q, state_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic        mem_err_q, mem_err_d;

    logic pc_write_raw, ir_write_raw, reg_write_raw;
    logic mem_write_raw, mem_read_raw, illegal_raw;
    logic wait_state, timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    always_comb begin
        wait_state = (state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                     (state_q == S_MEMWRITE);
        timeout    = wait_state && !mem_ready && (wait_cnt_q == WAIT_MAX);

        // Counting only while stalled in a wait state means it is already
        // zero whenever a wait state is entered.
        if (wait_state && !mem_ready)
            wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + 16'd1;
        else
            wait_cnt_d = '0;

        mem_err_d = mem_err_q | timeout;
    end

    always_comb begin
        state_d       = state_q;
        pc_write_raw  = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        mem_write_raw = 1'b0;
        mem_read_raw  = 1'b0;
        illegal_raw   = 1'b0;
        AdrSrc        = 1'b0;
        ResultSrc     = RES_ALUOUT;
        ALUSrcA       = SRCA_PC;
        ALUSrcB       = SRCB_REG;
        ALUOP         = ALUOP_ADD;

        case (state_q)
            S_FETCH: begin
                mem_read_raw = 1'b1;
                ALUSrcB      = SRCB_FOUR;
                ResultSrc    = RES_ALURES;
                pc_write_raw = mem_ready;
                ir_write_raw = mem_ready;
                if (mem_ready)    state_d = S_DECODE;
                else if (timeout) state_d = S_HALT;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BEQ:            state_d = S_BEQ;
                    OP_JAL:            state_d = S_JAL;
                    default: begin
                        state_d     = S_FETCH;
                        illegal_raw = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_REG;
                ALUSrcB = SRCB_IMM;
                state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_read_raw = 1'b1;
                AdrSrc       = 1'b1;
                if (mem_ready)    state_d = S_MEMWB;
                else if (timeout) state_d = S_HALT;
            end
            S_MEMWB: begin
                ResultSrc     = RES_DATA;
                reg_write_raw = 1'b1;
                state_d       = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_write_raw = 1'b1;
                AdrSrc        = 1'b1;
                if (mem_ready)    state_d = S_FETCH;
                else if (timeout) state_d = S_HALT;
            end
            S_EXECR: begin
                ALUSrcA = SRCA_REG;
                ALUSrcB = SRCB_REG;
                ALUOP   = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA = SRCA_REG;
                ALUSrcB = SRCB_IMM;
                ALUOP   = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_raw = 1'b1;
                state_d       = S_FETCH;
            end
            S_BEQ: begin
                ALUSrcA      = SRCA_REG;
                ALUSrcB      = SRCB_REG;
                ALUOP        = ALUOP_SUB;
                pc_write_raw = zero;
                state_d      = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA      = SRCA_OLDPC;
                ALUSrcB      = SRCB_FOUR;
                pc_write_raw = 1'b1;
                state_d      = S_ALUWB;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    // Strobes are masked by rst_n directly so they drop within the reset
    // cycle, not on the next edge.
    assign PCWrite       = pc_write_raw  & rst_n;
    assign IRWrite       = ir_write_raw  & rst_n;
    assign RegWrite      = reg_write_raw & rst_n;
    assign MemWrite      = mem_write_raw & rst_n;
    assign MemRead       = mem_read_raw  & rst_n;
    assign illegal_instr = illegal_raw   & rst_n;

    assign ImmSrc    = imm_src_of(op);
    assign mem_err   = mem_err_q;
    assign state_dbg = state_q;

    alu_decoder u_alu_decoder (
        .alu_op      (ALUOP),
        .funct3      (funct3),
        .funct7_5    (funct7_5),
        .op5         (op[5]),
        .alu_control (ALUControl)
    );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: per-cycle expected output vectors are
// derived from each instruction's state walk and queued by the driver; a
// negedge monitor pops and compares them against the DUT.
module tb_multicycle_ctrl;

    localparam int WAIT_MAX = 4;

    localparam logic [3:0] F = 4'd0, D = 4'd1, MA = 4'd2, MR = 4'd3, MWB = 4'd4,
                           MW = 4'd5, ER = 4'd6, EI = 4'd7, AW = 4'd8, BQ = 4'd9,
                           JL = 4'd10, HL = 4'd11;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                           IT = 7'b0010011, BR = 7'b1100011, JA = 7'b1101111;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] op = '0;
    logic [2:0] funct3 = '0;
    logic       funct7_5 = 1'b0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;

    logic       PCWrite, IRWrite, RegWrite, MemWrite, MemRead, AdrSrc;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUOP;
    logic [2:0] ALUControl;
    logic       mem_err, illegal_instr;
    logic [3:0] state_dbg;

    typedef logic [24:0] vec_t;
    vec_t exp_q[$];

    int   n_checks = 0;
    int   n_fail = 0;
    logic exp_err = 1'b0;
    logic in_reset = 1'b1;
    vec_t act;

    multicycle_ctrl #(.MEM_WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7_5(funct7_5),
        .zero(zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .MemWrite(MemWrite), .MemRead(MemRead), .AdrSrc(AdrSrc),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ImmSrc(ImmSrc), .ALUOP(ALUOP), .ALUControl(ALUControl),
        .mem_err(mem_err), .illegal_instr(illegal_instr), .state_dbg(state_dbg)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, queue=%0d", exp_q.size());
        $fatal(1, "watchdog");
    end

    assign act = {state_dbg, PCWrite, IRWrite, RegWrite, MemWrite, MemRead, AdrSrc,
                  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUOP, ALUControl,
                  mem_err, illegal_instr};

    function automatic logic is_legal(input logic [6:0] o);
        return (o == LW) || (o == SW) || (o == RT) || (o == IT) || (o == BR) || (o == JA);
    endfunction

    // Expected outputs for one cycle spent in state st.
    function automatic vec_t model(input logic [3:0] st, input logic rdy);
        logic pcw, irw, rw, mw, mr, adr, ill;
        logic [1:0] rs, sa, sb, imm, aop;
        logic [2:0] ctl;
        {pcw, irw, rw, mw, mr, adr, ill} = '0;
        {rs, sa, sb, aop} = '0;
        case (st)
            F:   begin mr = 1'b1; sb = 2'b10; rs = 2'b10; pcw = rdy; irw = rdy; end
            D:   begin sa = 2'b01; sb = 2'b01; ill = !is_legal(op); end
            MA:  begin sa = 2'b10; sb = 2'b01; end
            MR:  begin mr = 1'b1; adr = 1'b1; end
            MWB: begin rs = 2'b01; rw = 1'b1; end
            MW:  begin mw = 1'b1; adr = 1'b1; end
            ER:  begin sa = 2'b10; aop = 2'b10; end
            EI:  begin sa = 2'b10; sb = 2'b01; aop = 2'b10; end
            AW:  rw = 1'b1;
            BQ:  begin sa = 2'b10; aop = 2'b01; pcw = zero; end
            JL:  begin sa = 2'b01; sb = 2'b10; pcw = 1'b1; end
            default: ;
        endcase
        if (in_reset) {pcw, irw, rw, mw, mr, ill} = '0;
        if (op == SW) imm = 2'b01;
        else if (op == BR) imm = 2'b10;
        else if (op == JA) imm = 2'b11;
        else imm = 2'b00;
        if (aop == 2'b01) ctl = 3'b001;
        else if (aop == 2'b10) begin
            if (funct3 == 3'b111) ctl = 3'b010;
            else if (funct3 == 3'b110) ctl = 3'b011;
            else if (funct3 == 3'b010) ctl = 3'b101;
            else if (funct3 == 3'b000 && op[5] && funct7_5) ctl = 3'b001;
            else ctl = 3'b000;
        end else ctl = 3'b000;
        return {st, pcw, irw, rw, mw, mr, adr, rs, sa, sb, imm, aop, ctl, exp_err, ill};
    endfunction

    // scoreboard monitor
    always @(negedge clk) begin
        vec_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (act !== e) begin
                n_fail++;
                $display("FAIL cycle_vec t=%0t actual=%h expected=%h (state act=%0d exp=%0d)",
                         $time, act, e, act[24:21], e[24:21]);
            end
        end
    end

    task automatic check1(input string name, input logic [31:0] a, input logic [31:0] e);
        n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, a, e);
        end
    endtask

    // driver tasks: called at posedge+1, covering one full cycle each
    task automatic cyc(input logic [3:0] st, input logic rdy);
        mem_ready = rdy;
        exp_q.push_back(model(st, rdy));
        @(posedge clk);
        #1;
    endtask

    task automatic rnd_cyc(input logic [3:0] st);
        cyc(st, 1'($urandom_range(0, 1)));
    endtask

    task automatic wait_phase(input logic [3:0] st, input int stall);
        for (int i = 0; i < stall; i++) cyc(st, 1'b0);
        cyc(st, 1'b1);
    endtask

    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input logic z, input int fstall, input int mstall);
        op = o; funct3 = f3; funct7_5 = f7; zero = z;
        wait_phase(F, fstall);
        rnd_cyc(D);
        case (o)
            LW: begin rnd_cyc(MA); wait_phase(MR, mstall); rnd_cyc(MWB); end
            SW: begin rnd_cyc(MA); wait_phase(MW, mstall); end
            RT: begin rnd_cyc(ER); rnd_cyc(AW); end
            IT: begin rnd_cyc(EI); rnd_cyc(AW); end
            BR: rnd_cyc(BQ);
            JA: begin rnd_cyc(JL); rnd_cyc(AW); end
            default: ;
        endcase
    endtask

    initial begin
        logic [6:0] ro;
        logic [6:0] legal_ops[6];
        legal_ops = '{LW, SW, RT, IT, BR, JA};

        @(posedge clk);
        #1;
        // reset held: FETCH with strobes masked even with mem_ready high
        in_reset = 1'b1;
        cyc(F, 1'b0);
        cyc(F, 1'b1);
        rst_n = 1'b1;
        in_reset = 1'b0;

        // directed cases
        run_instr(LW, 3'b010, 1'b0, 1'b0, 0, 0);   // 0,1,2,3,4 in 5 cycles
        run_instr(SW, 3'b010, 1'b0, 1'b0, 0, 3);   // MemWrite held 4 cycles
        run_instr(RT, 3'b000, 1'b1, 1'b0, 1, 0);   // sub
        run_instr(IT, 3'b000, 1'b1, 1'b0, 0, 0);   // addi stays add
        run_instr(BR, 3'b000, 1'b0, 1'b1, 0, 0);   // taken
        run_instr(BR, 3'b000, 1'b0, 1'b0, 2, 0);   // not taken
        run_instr(JA, 3'b000, 1'b0, 1'b0, 0, 0);
        run_instr(7'b1111111, 3'b000, 1'b0, 1'b0, 0, 0);
        for (int k = 0; k < 4; k++)
            run_instr(RT, (k == 0) ? 3'b111 : (k == 1) ? 3'b110 : (k == 2) ? 3'b010 : 3'b001,
                      1'b0, 1'b0, 0, 0);

        // randomized instruction mix, stalls kept below the timeout
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 6) == 0) begin
                ro = 7'($urandom);
                while (is_legal(ro)) ro = 7'($urandom);
            end else begin
                ro = legal_ops[$urandom_range(0, 5)];
            end
            run_instr(ro, 3'($urandom), 1'($urandom), 1'($urandom),
                      $urandom_range(0, WAIT_MAX - 1), $urandom_range(0, WAIT_MAX - 1));
        end

        // reset asserted in the middle of MEMREAD
        op = LW;
        cyc(F, 1'b1);
        cyc(D, 1'b0);
        cyc(MA, 1'b0);
        mem_ready = 1'b0;
        #1;
        check1("memread_active", {31'd0, MemRead}, 32'd1);
        check1("memread_state", {28'd0, state_dbg}, 32'd3);
        rst_n = 1'b0;
        #1;
        check1("memread_drop", {31'd0, MemRead}, 32'd0);
        check1("reset_state", {28'd0, state_dbg}, 32'd0);
        @(posedge clk);
        #1;
        in_reset = 1'b1;
        cyc(F, 1'b0);
        rst_n = 1'b1;
        in_reset = 1'b0;
        run_instr(LW, 3'b010, 1'b0, 1'b0, 0, 1);

        // memory timeout in FETCH
        op = IT;
        funct3 = 3'b000;
        for (int i = 0; i <= WAIT_MAX; i++) cyc(F, 1'b0);
        exp_err = 1'b1;
        for (int i = 0; i < 5; i++) rnd_cyc(HL);
        rst_n = 1'b0;
        in_reset = 1'b1;
        exp_err = 1'b0;
        cyc(F, 1'b0);
        rst_n = 1'b1;
        in_reset = 1'b0;
        run_instr(RT, 3'b000, 1'b1, 1'b0, 0, 0);

        // timeout at the boundary while waiting in MEMWRITE
        op = SW;
        cyc(F, 1'b1);
        cyc(D, 1'b0);
        cyc(MA, 1'b0);
        for (int i = 0; i <= WAIT_MAX; i++) cyc(MW, 1'b0);
        exp_err = 1'b1;
        rnd_cyc(HL);
        rnd_cyc(HL);

        @(negedge clk);
        #1;
        check1("queue_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
